// File: rtl/mem_stage.sv
// Memory-access stage: ALU pass-through, multi-cycle loads/stores on internal data memory, one write-back beat.
// Optional byte access support is built only when MEM_STAGE_BYTE_EN is defined.
module mem_stage #(
    parameter int MEM_WORDS   = 1024,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        is_byte,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  regD,
    output logic        wb_valid,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        misaligned,
    output logic [1:0]  dbg_state
);

    // Handshake: an operation transfers on a rising edge where in_valid && in_ready;
    // upstream holds its operation while in_ready is low, and nothing is captured then.

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          op_load;
    logic          op_store;
    logic          op_byte;
    logic [AW+1:0] op_addr;
    logic [31:0]   op_sdata;
    logic [4:0]    op_rd;

    logic [31:0]   mem [MEM_WORDS];

    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic          op_mis;
    logic          access;
    logic [31:0]   rd_word;
    logic [31:0]   load_val;
    logic [31:0]   store_word;

    assign dbg_state = state;
    assign word_idx  = op_addr[AW+1:2];
    assign lane      = op_addr[1:0];
    assign op_mis    = (op_load | op_store) & ~op_byte & (lane != 2'd0);
    assign access    = (state == S_WAIT) && (cnt == '0);
    assign rd_word   = mem[word_idx];

`ifdef MEM_STAGE_BYTE_EN
    always_comb begin
        load_val   = rd_word;
        store_word = op_sdata;
        if (op_byte) begin
            load_val   = {24'd0, rd_word[{lane, 3'b000} +: 8]};
            // Read-modify-write keeps the three untouched lanes intact.
            store_word = rd_word;
            store_word[{lane, 3'b000} +: 8] = op_sdata[7:0];
        end
    end
`else
    logic unused_is_byte;
    assign unused_is_byte = is_byte;
    assign op_byte        = 1'b0;
    assign load_val       = rd_word;
    assign store_word     = op_sdata;
`endif

    // Memory contents survive reset; reset only blocks a pending commit.
    always_ff @(posedge clk) begin
        if (!reset && access && op_store && !op_mis) begin
            mem[word_idx] <= store_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            in_ready   <= 1'b1;
            op_load    <= 1'b0;
            op_store   <= 1'b0;
`ifdef MEM_STAGE_BYTE_EN
            op_byte    <= 1'b0;
`endif
            op_addr    <= '0;
            op_sdata   <= '0;
            op_rd      <= '0;
            wb_valid   <= 1'b0;
            wb_en      <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            misaligned <= 1'b0;
        end else begin
            wb_valid   <= 1'b0;
            wb_en      <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            misaligned <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_load  <= is_load;
                        op_store <= is_store;
`ifdef MEM_STAGE_BYTE_EN
                        op_byte  <= is_byte;
`endif
                        op_addr  <= alu_result[AW+1:0];
                        op_sdata <= store_data;
                        op_rd    <= regD;
                        in_ready <= 1'b0;
                        if (is_load || is_store) begin
                            state <= S_WAIT;
                            cnt   <= CNT_INIT;
                        end else begin
                            state    <= S_RESP;
                            wb_valid <= 1'b1;
                            wb_en    <= (regD != 5'd0);
                            wb_addr  <= regD;
                            wb_data  <= alu_result;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state      <= S_RESP;
                        wb_valid   <= 1'b1;
                        wb_addr    <= op_rd;
                        misaligned <= op_mis;
                        wb_en      <= op_load && !op_mis && (op_rd != 5'd0);
                        wb_data    <= (op_load && !op_mis) ? load_val : 32'd0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: randomized and directed ops checked against a word-array reference model.
// Byte scenarios run only when MEM_STAGE_BYTE_EN is defined.
module tb_mem_stage;

    localparam int WORDS = 1024;
    localparam int LAT   = 2;
`ifdef MEM_STAGE_BYTE_EN
    localparam bit BYTE_EN = 1'b1;
`else
    localparam bit BYTE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic        is_byte = 1'b0;
    logic [31:0] alu_result = '0;
    logic [31:0] store_data = '0;
    logic [4:0]  regD = '0;
    logic        wb_valid;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        misaligned;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] ref_mem [WORDS];
    logic [31:0] exp_q [$];

    mem_stage #(.MEM_WORDS(WORDS), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .is_load(is_load), .is_store(is_store), .is_byte(is_byte),
        .alu_result(alu_result), .store_data(store_data), .regD(regD),
        .wb_valid(wb_valid), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .misaligned(misaligned), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Reference: what the write-back beat must carry, and how memory changes.
    task automatic model_op(input bit ld, input bit st, input bit byt, input logic [31:0] a,
                            input logic [31:0] sd, input logic [4:0] rd,
                            output bit en, output logic [31:0] data, output bit mis);
        int idx;
        int ln;
        bit bacc;
        idx  = int'((a >> 2) % WORDS);
        ln   = int'(a % 4);
        bacc = BYTE_EN && byt;
        mis  = (ld || st) && !bacc && (ln != 0);
        en   = 1'b0;
        data = 32'd0;
        if (mis) begin
            en = 1'b0;
        end else if (st) begin
            if (bacc)
                ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << (8 * ln))) | ((sd & 32'hFF) << (8 * ln));
            else
                ref_mem[idx] = sd;
        end else if (ld) begin
            data = bacc ? ((ref_mem[idx] >> (8 * ln)) & 32'hFF) : ref_mem[idx];
            en   = (rd != 0);
        end else begin
            data = a;
            en   = (rd != 0);
        end
    endtask

    // Driver + checker for one operation; expects to start and end at a negedge.
    task automatic do_op(input bit ld, input bit st, input bit byt, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] rd, input bit hold,
                         output logic [31:0] obs);
        bit          e_en;
        bit          e_mis;
        logic [31:0] e_data;
        int          lat;
        int          e_lat;
        int          w;
        model_op(ld, st, byt, a, sd, rd, e_en, e_data, e_mis);
        exp_q.push_back(e_data);
        e_lat = (ld || st) ? LAT + 1 : 1;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_wait: in_ready=%b required 1", in_ready);
        end
        is_load = ld; is_store = st; is_byte = byt;
        alu_result = a; store_data = sd; regD = rd; in_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                n_vec++;
                if (in_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL busy_ready: in_ready=%b required 0", in_ready);
                end
                if (hold) begin
                    is_load = $urandom_range(0, 1); is_store = 1'b0; is_byte = $urandom_range(0, 1);
                    alu_result = $urandom(); store_data = $urandom(); regD = 5'($urandom());
                end else begin
                    in_valid = 1'b0;
                end
            end
        end while (wb_valid !== 1'b1 && lat < 20);
        in_valid = 1'b0;
        obs = wb_data;
        e_data = exp_q.pop_front();
        n_vec++;
        if (wb_valid !== 1'b1 || lat != e_lat) begin
            n_bad++;
            $display("FAIL latency: got %0d cycles (wb_valid=%b) required %0d", lat, wb_valid, e_lat);
        end
        n_vec++;
        if (wb_en !== e_en) begin
            n_bad++;
            $display("FAIL wb_en: got %b required %b (a=%h ld=%b st=%b)", wb_en, e_en, a, ld, st);
        end
        n_vec++;
        if (wb_addr !== rd) begin
            n_bad++;
            $display("FAIL wb_addr: got %0d required %0d", wb_addr, rd);
        end
        n_vec++;
        if (wb_data !== e_data) begin
            n_bad++;
            $display("FAIL wb_data: got %h required %h (a=%h ld=%b st=%b byt=%b)", wb_data, e_data, a, ld, st, byt);
        end
        n_vec++;
        if (misaligned !== e_mis) begin
            n_bad++;
            $display("FAIL misaligned: got %b required %b (a=%h)", misaligned, e_mis, a);
        end
        @(negedge clk);
        n_vec++;
        if (wb_valid !== 1'b0 || wb_en !== 1'b0 || wb_data !== 32'd0 || wb_addr !== 5'd0 ||
            misaligned !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL after_beat: wb_valid=%b wb_en=%b wb_data=%h wb_addr=%0d mis=%b in_ready=%b required 0,0,0,0,0,1",
                     wb_valid, wb_en, wb_data, wb_addr, misaligned, in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b1;
        alu_result = 32'hFFFF_FFFF; regD = 5'd9;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || wb_valid !== 1'b0 || wb_en !== 1'b0 || wb_addr !== 5'd0 ||
            wb_data !== 32'd0 || misaligned !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: in_ready=%b wb_valid=%b wb_en=%b wb_addr=%0d wb_data=%h mis=%b required 1,0,0,0,0,0",
                     in_ready, wb_valid, wb_en, wb_addr, wb_data, misaligned);
        end
    endtask

    task automatic test_fill();
        logic [31:0] obs;
        for (int i = 0; i < 16; i++)
            do_op(1'b0, 1'b1, 1'b0, 32'(i * 4), $urandom(), 5'($urandom()), 1'b0, obs);
    endtask

    task automatic test_alu_pass();
        logic [31:0] obs;
        do_op(1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'd0, 5'd5, 1'b0, obs);
        n_vec++;
        if (obs !== 32'h0000_1234) begin
            n_bad++;
            $display("FAIL alu_pass: got %h required 00001234", obs);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] obs;
        do_op(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 5'd3, 1'b0, obs);
        do_op(1'b1, 1'b0, 1'b0, 32'h10, 32'd0, 5'd7, 1'b0, obs);
        n_vec++;
        if (obs !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL store_load: got %h required deadbeef", obs);
        end
    endtask

    task automatic test_misaligned_wrap();
        logic [31:0] obs;
        do_op(1'b0, 1'b1, 1'b0, 32'h11, 32'h1234_5678, 5'd4, 1'b0, obs);
        do_op(1'b1, 1'b0, 1'b0, 32'h10, 32'd0, 5'd8, 1'b0, obs);
        n_vec++;
        if (obs !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL misaligned_untouched: got %h required deadbeef", obs);
        end
        do_op(1'b1, 1'b0, 1'b0, 32'h1010, 32'd0, 5'd9, 1'b0, obs);
        n_vec++;
        if (obs !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL wrap_load: got %h required deadbeef", obs);
        end
    endtask

`ifdef MEM_STAGE_BYTE_EN
    task automatic test_byte();
        logic [31:0] obs;
        do_op(1'b0, 1'b1, 1'b1, 32'h12, 32'h0000_0055, 5'd2, 1'b0, obs);
        do_op(1'b1, 1'b0, 1'b0, 32'h10, 32'd0, 5'd6, 1'b0, obs);
        n_vec++;
        if (obs !== 32'hDE55_BEEF) begin
            n_bad++;
            $display("FAIL byte_store: got %h required de55beef", obs);
        end
        do_op(1'b1, 1'b0, 1'b1, 32'h13, 32'd0, 5'd6, 1'b0, obs);
        n_vec++;
        if (obs !== 32'h0000_00DE) begin
            n_bad++;
            $display("FAIL byte_load: got %h required 000000de", obs);
        end
    endtask
`endif

    task automatic test_hold_valid();
        logic [31:0] obs;
        do_op(1'b0, 1'b1, 1'b0, 32'h24, 32'hCAFE_F00D, 5'd1, 1'b1, obs);
        do_op(1'b1, 1'b0, 1'b0, 32'h24, 32'd0, 5'd10, 1'b1, obs);
        n_vec++;
        if (obs !== 32'hCAFE_F00D) begin
            n_bad++;
            $display("FAIL hold_valid: got %h required cafef00d", obs);
        end
        do_op(1'b0, 1'b0, 1'b0, 32'h0BAD_0001, 32'd0, 5'd11, 1'b1, obs);
    endtask

    task automatic test_reset_mid();
        logic [31:0] old;
        logic [31:0] obs;
        bit          seen;
        old = ref_mem[8];
        is_load = 1'b0; is_store = 1'b1; is_byte = 1'b0;
        alu_result = 32'h20; store_data = ~old; regD = 5'd12; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        // Reset lands on the edge that would have committed the store.
        repeat (LAT - 1) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen = (wb_valid === 1'b1);
        repeat (5) begin
            @(negedge clk);
            if (wb_valid === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (seen || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid: wb_valid_seen=%b in_ready=%b required 0,1", seen, in_ready);
        end
        do_op(1'b1, 1'b0, 1'b0, 32'h20, 32'd0, 5'd13, 1'b0, obs);
        n_vec++;
        if (obs !== old) begin
            n_bad++;
            $display("FAIL reset_discard: got %h required %h", obs, old);
        end
    endtask

    task automatic test_rd_zero();
        logic [31:0] obs;
        do_op(1'b1, 1'b0, 1'b0, 32'h10, 32'd0, 5'd0, 1'b0, obs);
        do_op(1'b0, 1'b0, 1'b0, 32'h5555_AAAA, 32'd0, 5'd0, 1'b0, obs);
    endtask

    task automatic test_random();
        logic [31:0] obs;
        logic [31:0] a;
        int          kind;
        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 2);
            a = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            if (kind == 0) a = $urandom();
            do_op(kind == 1, kind == 2, 1'($urandom_range(0, 1)), a, $urandom(),
                  5'($urandom()), 1'($urandom_range(0, 1)), obs);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_fill();
        test_alu_pass();
        test_store_load();
        test_misaligned_wrap();
`ifdef MEM_STAGE_BYTE_EN
        test_byte();
`endif
        test_hold_valid();
        test_reset_mid();
        test_rd_zero();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the MIRI processor, directly downstream of the ALU stage. Takes the ALU result (used as result or as data address), the regB data (store data) and the destination register index. Performs loads/stores against an internal data memory with fixed multi-cycle latency, then presents a single write-back beat that drives the register file write port.

## Interface
- MEM_WORDS, 1024: data memory depth in 32-bit words; power of two, ≥ 4.
- MEM_LATENCY, 2: wait cycles per memory access; ≥ 1.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  ALU stage presents an operation.
- in_ready  output  1  stage can accept an operation this cycle.
- is_load  input  1  operation is a load.
- is_store  input  1  operation is a store; is_load and is_store never both high.
- is_byte  input  1  byte access instead of word access (see Configuration).
- alu_result  input  32  ALU output: write-back value, or byte address for load/store.
- store_data  input  32  regB data to store.
- regD  input  5  destination register index.
- wb_valid  output  1  one-cycle write-back beat.
- wb_en  output  1  register file write enable; valid only with wb_valid.
- wb_addr  output  5  register file write address.
- wb_data  output  32  register file write data.
- misaligned  output  1  one-cycle flag with wb_valid: word access with address bits [1:0] ≠ 0.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: in_ready = 1. Accept on in_valid & in_ready; latch op type, address, store data and regD.
  - ALU-only op (neither load nor store): go to RESP.
  - Load/store: go to WAIT and load the wait counter with MEM_LATENCY−1.
- WAIT: in_ready = 0. Decrement counter each cycle. When the counter is 0, perform the access and go to RESP.
  - Store: memory written on that edge.
  - Load: read data latched on that edge.
- RESP: in_ready = 0. wb_valid = 1 for exactly one cycle, then go to IDLE.
- Address: word index = alu_result[log2(MEM_WORDS)+1:2]; upper bits ignored, so addresses wrap modulo MEM_WORDS words. Byte lane = alu_result[1:0], little-endian (lane 0 = bits 7:0).
- Write-back:
  - ALU-only op: wb_data = alu_result.
  - Load: wb_data = memory data.
  - Store: wb_data = 0, wb_en = 0.
  - wb_en for ALU-only and load = (regD ≠ 0). wb_addr = latched regD.
- Misaligned word load/store: memory untouched, wb_en = 0, wb_data = 0, misaligned = 1 in RESP. Latency is unchanged.
- Byte store writes only the addressed lane; the other three bytes are preserved. Byte load returns the addressed byte zero-extended to 32 bits. Byte accesses are never misaligned.

## Timing
- Reset: state IDLE, counter 0. in_ready = 1 on the first cycle after reset is released. wb_valid = 0, wb_en = 0, wb_addr = 0, wb_data = 0, misaligned = 0. Memory contents are not reset.
- Latency from accept edge to wb_valid cycle:
  - ALU-only: 1 cycle.
  - Load/store: MEM_LATENCY+1 cycles.
- Next accept is possible in the cycle after RESP. Throughput is one op per 2 cycles (ALU-only) or MEM_LATENCY+2 cycles (memory).
- in_valid while in_ready = 0 is ignored; inputs are not captured. The upstream stage holds its operation.
- Reset mid-operation (WAIT or RESP): return to IDLE next edge. A store not yet committed is discarded. No wb_valid is produced.
- All outputs are registered. wb_* and misaligned are held at 0 whenever wb_valid = 0.

## Configuration
- MEM_STAGE_BYTE_EN defined: byte loads/stores are supported as described above.
- MEM_STAGE_BYTE_EN undefined:
  - is_byte is ignored; every access is a word access, including the misaligned check.
  - No byte-lane muxing or partial-write logic is built.

## Test plan
- ALU pass-through: alu_result = 0x0000_1234, regD = 5, no load/store → wb_valid 1 cycle after accept, wb_en = 1, wb_addr = 5, wb_data = 0x0000_1234.
- Store then load, MEM_LATENCY = 2:
  - Store 0xDEAD_BEEF at 0x10 → wb_valid 3 cycles after accept, wb_en = 0.
  - Load 0x10 into regD = 7 → wb_data = 0xDEAD_BEEF, wb_en = 1, wb_addr = 7, 3 cycles after accept.
- Byte ops (macro defined), after the word store above:
  - Byte store 0x55 at 0x12 → subsequent word load at 0x10 returns 0xDE55_BEEF.
  - Byte load at 0x13 returns 0x0000_00DE.
- Misaligned and wrap:
  - Word store at 0x11 → misaligned = 1, memory unchanged.
  - With MEM_WORDS = 1024, a load at 0x1010 returns the word stored at 0x10.
- Hazards:
  - in_valid held high during WAIT → no second capture.
  - Reset asserted during WAIT of a store to 0x20 → no wb_valid; a later load from 0x20 returns the old contents.
- regD = 0 load → wb_valid = 1 with wb_en = 0.
